ad400x_spi_engine: RTL

AD400X_SPI_ENGINE -- requirements
Module: ad400x_spi_engine

---
 rtl/ad400x_pkg.sv | 30 +++
 rtl/ad400x_spi_engine_if.sv | 32 +++
 rtl/ad400x_sclk_gen.sv | 36 +++
 rtl/ad400x_spi_engine.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ad400x_pkg.sv
// Shared definitions for the AD400x SPI engine: mode and state encodings,
// ADC register commands and the expected configuration pattern.
package ad400x_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_ACQ  = 2'd1,
    MODE_WR   = 2'd2,
    MODE_RD   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CONV = 3'd1,
    ST_GAP  = 3'd2,
    ST_XFER = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  localparam logic [7:0] CMD_WR      = 8'h14;
  localparam logic [7:0] CMD_RD      = 8'h54;
  localparam logic [7:0] CFG_DEFAULT = 8'h03;
  localparam logic [4:0] CFG_OK      = 5'b00011;

  // A frame is never shorter than the 16-bit command word.
  function automatic int frame_len(input int data_w);
    return (data_w > 16) ? data_w : 16;
  endfunction

endpackage

// File: rtl/ad400x_spi_engine_if.sv
// Bus between the AD400x SPI engine and its controller / ADC pins.
interface ad400x_spi_engine_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 18
);
  logic                     start;
  logic [1:0]               mode;
  logic [7:0]               reg_wdata;
  logic [NUM_CH-1:0]        sdo_in;
  logic                     cnv;
  logic                     sclk;
  logic                     sdi;
  logic                     busy;
  logic                     done;
  logic [NUM_CH*DATA_W-1:0] data_out;
  logic                     data_valid;
  logic [NUM_CH*8-1:0]      reg_rdata;
  logic                     cfg_ok;
  logic [15:0]              overrun_cnt;

  modport master (
    output start, mode, reg_wdata, sdo_in,
    input  cnv, sclk, sdi, busy, done, data_out, data_valid,
           reg_rdata, cfg_ok, overrun_cnt
  );

  modport slave (
    input  start, mode, reg_wdata, sdo_in,
    output cnv, sclk, sdi, busy, done, data_out, data_valid,
           reg_rdata, cfg_ok, overrun_cnt
  );
endinterface

// File: rtl/ad400x_sclk_gen.sv
// SCLK generator: low phase first, each phase SCLK_DIV clk_100 cycles.
// rise/fall flag the cycle whose closing edge moves sclk high/low.
module ad400x_sclk_gen #(
  parameter int SCLK_DIV = 1
) (
  input  logic clk_100,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);
  logic [3:0] cnt;
  logic       half_end;

  // Phase-end detect and edge strobes.
  always_comb begin
    half_end = (cnt == 4'(SCLK_DIV - 1));
    rise     = en & ~sclk & half_end;
    fall     = en & sclk & half_end;
  end

  // Half-period counter and sclk toggle; parked low whenever disabled.
  always_ff @(posedge clk_100) begin
    if (!rst_n || !en) begin
      cnt  <= 4'd0;
      sclk <= 1'b0;
    end else if (half_end) begin
      cnt  <= 4'd0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 4'd1;
      sclk <= sclk;
    end
  end
endmodule

// File: rtl/ad400x_spi_engine.sv
// AD400x multi-channel SPI engine: CNV pulse, gap, then one shared SCLK
// frame that shifts a command out on sdi and samples every channel's sdo.
// Optional: define AD400X_OVERRUN_CNT_EN to build the overrun counter.
module ad400x_spi_engine
  import ad400x_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 18,
  parameter int SCLK_DIV = 1,
  parameter int CNV_CYC  = 40
) (
  input logic               clk_100,
  input logic               rst_n,
  ad400x_spi_engine_if.slave bus
);
  localparam int FRAME_LEN = frame_len(DATA_W);
  localparam int BIT_W     = $clog2(FRAME_LEN + 1);

  state_e                   state, next_state;
  mode_e                    frame_mode;
  logic [7:0]               frame_wdata;
  logic [7:0]               cnv_cnt;
  logic [BIT_W-1:0]         bit_cnt;
  logic [FRAME_LEN-1:0]     tx_sr, tx_load;
  logic [FRAME_LEN-2:0]     rx_sr   [NUM_CH];
  logic [FRAME_LEN-1:0]     rx_next [NUM_CH];
  logic                     sclk, sclk_rise, sclk_fall;
  logic                     xfer_en, last_bit, start_ok;
  logic                     cnv_q, busy_q, done_q, valid_q, cfg_all;
  logic [NUM_CH*DATA_W-1:0] data_q;
  logic [NUM_CH*8-1:0]      rdata_q;

  ad400x_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .en      (xfer_en),
    .sclk    (sclk),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  // Next-state logic; bit_cnt counts rising edges, so the frame ends on the
  // falling edge after the FRAME_LEN-th rise.
  always_comb begin
    next_state = state;
    xfer_en    = (state == ST_XFER);
    start_ok   = bus.start && (state == ST_IDLE) && (mode_e'(bus.mode) != MODE_IDLE);
    last_bit   = sclk_fall && (bit_cnt == BIT_W'(FRAME_LEN));
    case (state)
      ST_IDLE: if (start_ok) next_state = ST_CONV; else next_state = ST_IDLE;
      ST_CONV: if (cnv_cnt == 8'(CNV_CYC - 1)) next_state = ST_GAP; else next_state = ST_CONV;
      ST_GAP:  next_state = ST_XFER;
      ST_XFER: if (last_bit) next_state = ST_FIN; else next_state = ST_XFER;
      ST_FIN:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Outgoing word: 16-bit command left-aligned, padded with ones.
  always_comb begin
    tx_load = {FRAME_LEN{1'b1}};
    case (frame_mode)
      MODE_WR: tx_load[FRAME_LEN-1 -: 16] = {CMD_WR, frame_wdata};
      MODE_RD: tx_load[FRAME_LEN-1 -: 16] = {CMD_RD, 8'hFF};
      default: tx_load = {FRAME_LEN{1'b1}};
    endcase
  end

  // Per-channel receive word including the bit being sampled this cycle.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      rx_next[k] = {rx_sr[k], bus.sdo_in[k]};
    end
  end

  // State register and registered frame-level outputs.
  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= next_state;
      cnv_q   <= (next_state == ST_CONV);
      busy_q  <= (next_state != ST_IDLE);
      done_q  <= (next_state == ST_FIN);
      valid_q <= (next_state == ST_FIN) && (frame_mode == MODE_ACQ);
    end
  end

  // Frame parameters captured at accept, plus CNV and bit counters.
  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      frame_mode  <= MODE_IDLE;
      frame_wdata <= 8'h00;
      cnv_cnt     <= 8'd0;
      bit_cnt     <= {BIT_W{1'b0}};
    end else begin
      if (start_ok) begin
        frame_mode  <= mode_e'(bus.mode);
        frame_wdata <= bus.reg_wdata;
      end else begin
        frame_mode  <= frame_mode;
        frame_wdata <= frame_wdata;
      end
      cnv_cnt <= (state == ST_CONV) ? cnv_cnt + 8'd1 : 8'd0;
      if (!xfer_en) bit_cnt <= {BIT_W{1'b0}};
      else if (sclk_rise) bit_cnt <= bit_cnt + {{(BIT_W-1){1'b0}}, 1'b1};
      else bit_cnt <= bit_cnt;
    end
  end

  // sdi shifter: loaded in GAP, advances as each high phase closes.
  always_ff @(posedge clk_100) begin
    if (!rst_n) tx_sr <= {FRAME_LEN{1'b1}};
    else if (state == ST_GAP) tx_sr <= tx_load;
    else if (sclk_fall) tx_sr <= {tx_sr[FRAME_LEN-2:0], 1'b1};
    else tx_sr <= tx_sr;
  end

  // sdo shifters: sample every channel as sclk drops.
  always_ff @(posedge clk_100) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (!rst_n) rx_sr[k] <= {(FRAME_LEN-1){1'b0}};
      else if (sclk_fall) rx_sr[k] <= rx_next[k][FRAME_LEN-2:0];
      else rx_sr[k] <= rx_sr[k];
    end
  end

  // Result capture on the final sample; read data is the second received byte.
  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      data_q  <= {(NUM_CH*DATA_W){1'b0}};
      rdata_q <= {(NUM_CH*8){1'b0}};
    end else if (last_bit) begin
      for (int k = 0; k < NUM_CH; k++) begin
        case (frame_mode)
          MODE_ACQ: data_q[k*DATA_W +: DATA_W] <= rx_next[k][FRAME_LEN-1 -: DATA_W];
          MODE_RD:  rdata_q[k*8 +: 8]          <= rx_next[k][FRAME_LEN-9 -: 8];
          default:  data_q <= data_q;
        endcase
      end
    end else begin
      data_q  <= data_q;
      rdata_q <= rdata_q;
    end
  end

  // Configuration is good only when every channel reads back CFG_OK.
  always_comb begin
    cfg_all = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      cfg_all = cfg_all & (rdata_q[k*8 +: 5] == CFG_OK);
    end
  end

`ifdef AD400X_OVERRUN_CNT_EN
  logic [15:0] overrun_q;

  // Saturating count of starts arriving while a frame is in flight.
  always_ff @(posedge clk_100) begin
    if (!rst_n) overrun_q <= 16'h0000;
    else if (bus.start && (state != ST_IDLE) && (overrun_q != 16'hFFFF)) overrun_q <= overrun_q + 16'h0001;
    else overrun_q <= overrun_q;
  end
  assign bus.overrun_cnt = overrun_q;
`else
  assign bus.overrun_cnt = 16'h0000;
`endif

  assign bus.cnv        = cnv_q;
  assign bus.sclk       = sclk;
  assign bus.sdi        = tx_sr[FRAME_LEN-1];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.data_valid = valid_q;
  assign bus.data_out   = data_q;
  assign bus.reg_rdata  = rdata_q;
  assign bus.cfg_ok     = cfg_all;
endmodule
